// File: rtl/mult_seq_param.sv
// rtl/mult_seq_param.sv - parametrised sequential shift-add multiplier (FSM + datapath)
//
// Purpose: multiplies op_a by op_b with one add/shift step per multiplier bit,
// terminating early once the remaining multiplier bits are all zero. The product
// is presented on result while done is high for DONE_HOLD cycles.
//
// Parameters:
//   WIDTH      operand width (2..32); result is 2*WIDTH bits
//   DONE_HOLD  cycles done stays high before returning to IDLE (1..255)
//
// Optional build macro:
//   MULT_SIGNED_EN  operands are two's complement; product is signed
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous reset, active-high
//   init    in   start request, sampled only in IDLE
//   op_a    in   multiplicand, captured on accepted init
//   op_b    in   multiplier, captured on accepted init
//   busy    out  high in every state except IDLE
//   done    out  high exactly while in DONE
//   result  out  product, valid while done, held until replaced by the next product

module mult_seq_param #(
    parameter int WIDTH     = 16,
    parameter int DONE_HOLD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     mcand_r;
    logic [PW-1:0]     acc_r;
    logic [PW-1:0]     result_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [7:0]        hold_cnt;
    logic              hold_end;

    // Operand magnitudes loaded into the shift-add datapath, and the value
    // committed to result when the multiplier runs out of set bits.
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [PW-1:0]     acc_final;

`ifdef MULT_SIGNED_EN
    logic              sign_r;

    // Negating -2^(WIDTH-1) wraps to itself, which read as unsigned is the
    // correct magnitude 2^(WIDTH-1).
    assign mag_a     = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    assign mag_b     = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
    assign acc_final = sign_r ? (~acc_r + 1'b1) : acc_r;
`else
    assign mag_a     = op_a;
    assign mag_b     = op_b;
    assign acc_final = acc_r;
`endif

    assign hold_end = (hold_cnt == 8'(DONE_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (init) state_nx = S_CHECK;
            S_CHECK: begin
                if (mplier_r == '0)     state_nx = S_DONE;
                else if (mplier_r[0])   state_nx = S_ADD;
                else                    state_nx = S_SHIFT;
            end
            S_ADD:   state_nx = S_SHIFT;
            S_SHIFT: state_nx = S_CHECK;
            S_DONE:  if (hold_end) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            result_r <= '0;
            hold_cnt <= '0;
`ifdef MULT_SIGNED_EN
            sign_r   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (init) begin
                        mcand_r  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_r <= mag_b;
                        acc_r    <= '0;
`ifdef MULT_SIGNED_EN
                        sign_r   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`endif
                    end
                end
                S_CHECK: begin
                    // Leaving for DONE: commit the product and arm the hold counter.
                    if (mplier_r == '0) begin
                        acc_r    <= acc_final;
                        result_r <= acc_final;
                        hold_cnt <= '0;
                    end
                end
                S_ADD: begin
                    acc_r <= acc_r + mcand_r;
                end
                S_SHIFT: begin
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                end
                S_DONE: begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign result = result_r;

endmodule

// File: tb/tb_mult_seq_param.sv
// tb/tb_mult_seq_param.sv - self-checking bench for mult_seq_param

module tb_mult_seq_param;

    localparam int W    = 16;
    localparam int HOLD = 10;

    logic           clk;
    logic           rst;
    logic           init;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    int checks;
    int errors;

    mult_seq_param #(.WIDTH(W), .DONE_HOLD(HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
`ifdef MULT_SIGNED_EN
        logic [W-1:0] n;
        n = -v;
        return v[W-1] ? n : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
        longint      pa;
        longint      pb;
        longint      prod;
        logic [63:0] bits;
`ifdef MULT_SIGNED_EN
        pa = longint'($signed(a));
        pb = longint'($signed(b));
`else
        pa = longint'({48'd0, a});
        pb = longint'({48'd0, b});
`endif
        prod = pa * pb;
        bits = prod;
        return bits[2*W-1:0];
    endfunction

    // Edges from the init-sampling edge to the done-rise edge, both counted.
    function automatic int model_latency(input logic [W-1:0] b);
        logic [W-1:0] m;
        int p;
        int pop;
        m   = magnitude(b);
        p   = 0;
        pop = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                p = i + 1;
                pop++;
            end
        end
        return 2 + 2 * p + pop;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s idle_timeout busy=%0b required=0", name, busy);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [2*W-1:0] exp_p;
        int exp_lat;
        int n;
        int cnt;
        exp_p   = model_product(a, b);
        exp_lat = model_latency(b);
        wait_idle(name);
        @(negedge clk);
        op_a = a;
        op_b = b;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_init got=%0b required=1", name, busy);
        end
        n = 1;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== exp_lat) begin
            errors++;
            $display("FAIL %s latency got=%0d required=%0d", name, n, exp_lat);
        end
        checks++;
        if (result !== exp_p) begin
            errors++;
            $display("FAIL %s result got=%h required=%h", name, result, exp_p);
        end
        cnt = 0;
        while (done === 1'b1 && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (cnt !== HOLD || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_hold got=%0d busy=%0b required=%0d busy=0", name, cnt, busy, HOLD);
        end
        checks++;
        if (result !== exp_p) begin
            errors++;
            $display("FAIL %s result_held got=%h required=%h", name, result, exp_p);
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        init = 1'b1;
        op_a = 16'h1111;
        op_b = 16'h0003;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset busy=%0b done=%0b result=%h required 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst  = 1'b0;
        init = 1'b0;
    endtask

    task automatic test_directed;
        run_op(16'd3, 16'd1, "three_x_one");
        run_op(16'hFFFF, 16'hFFFF, "max_x_max");
        run_op(16'h1234, 16'h0000, "b_zero");
        run_op(16'h0000, 16'h8000, "a_zero_b_msb");
    endtask

    task automatic test_reset_mid;
        wait_idle("reset_mid");
        @(negedge clk);
        op_a = 16'h1234;
        op_b = 16'h00FF;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_mid busy=%0b done=%0b result=%h required 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd7, 16'd6, "after_reset_7x6");
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 3 == 0) b = b >> $urandom_range(W - 1, 8);
            run_op(a, b, $sformatf("random_%0d", i));
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int cnt;
        wait_idle("b2b");
        @(negedge clk);
        op_a = 16'd5;
        op_b = 16'd5;
        init = 1'b1;
        @(posedge clk);
        #1;
        op_a = 16'd9;
        op_b = 16'd3;
        n = 1;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== model_latency(16'd5) || result !== model_product(16'd5, 16'd5)) begin
            errors++;
            $display("FAIL b2b_first lat=%0d result=%h required lat=%0d result=%h",
                     n, result, model_latency(16'd5), model_product(16'd5, 16'd5));
        end
        cnt = 0;
        while (done === 1'b1 && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (cnt !== HOLD || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap hold=%0d busy=%0b required hold=%0d busy=0", cnt, busy, HOLD);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_start busy=%0b required=1", busy);
        end
        n = 1;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== model_latency(16'd3) || result !== model_product(16'd9, 16'd3)) begin
            errors++;
            $display("FAIL b2b_second lat=%0d result=%h required lat=%0d result=%h",
                     n, result, model_latency(16'd3), model_product(16'd9, 16'd3));
        end
        // Toggle init throughout DONE: it must neither shorten nor restart the hold.
        cnt = 0;
        while (done === 1'b1 && cnt < 300) begin
            @(negedge clk);
            init = ~init;
            @(posedge clk);
            #1;
            cnt++;
        end
        @(negedge clk);
        init = 1'b0;
        checks++;
        if (cnt !== HOLD) begin
            errors++;
            $display("FAIL b2b_init_in_done hold=%0d required=%0d", cnt, HOLD);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || result !== model_product(16'd9, 16'd3)) begin
            errors++;
            $display("FAIL b2b_settle busy=%0b result=%h required busy=0 result=%h",
                     busy, result, model_product(16'd9, 16'd3));
        end
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed;
        run_op(16'h8000, 16'h8000, "signed_min_x_min");
        run_op(-16'sd3, 16'sd5, "signed_m3_x_5");
        run_op(16'sd7, -16'sd1, "signed_7_x_m1");
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom), W'($urandom), $sformatf("signed_random_%0d", i));
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        init   = 1'b0;
        op_a   = '0;
        op_b   = '0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
